// File: rtl/minterm_scanner.sv
// Truth-table reader for 4-input single-output minterm blocks. It sweeps
// inputs 0..15, builds a mask and popcount, then streams the set indices.
module minterm_scanner #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        scan_en,
    output logic [3:0]  i_out,
    output logic        en_out,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] mask,
    output logic [4:0]  count,
    output logic        mt_valid,
    output logic [3:0]  mt_index,
    input  logic        mt_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [2:0] SETTLE_W = 3'(SETTLE);

    state_t      state_r, state_s;
    logic [3:0]  ptr_r, ptr_s;
    logic [2:0]  wait_r, wait_s;
    logic [15:0] mask_s;
    logic [4:0]  count_s;
    logic        mt_valid_s;

    // Next-state, pointer, settle-window and result computation
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        wait_s  = wait_r;
        mask_s  = mask;
        count_s = count;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SCAN;
                    ptr_s   = 4'd0;
                    wait_s  = 3'd0;
                    mask_s  = 16'd0;
                    count_s = 5'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                // Sample on the last cycle of the window; pointer wraps 15 -> 0
                if (wait_r == SETTLE_W) begin
                    mask_s[ptr_r] = y_in;
                    if (y_in) begin
                        count_s = count + 5'd1;
                    end else begin
                        count_s = count;
                    end
                    wait_s = 3'd0;
                    ptr_s  = ptr_r + 4'd1;
                    if (ptr_r == 4'd15) begin
                        state_s = EMIT;
                    end else begin
                        state_s = SCAN;
                    end
                end else begin
                    wait_s = wait_r + 3'd1;
                end
            end
            EMIT: begin
                if (!mask[ptr_r] || mt_ready) begin
                    ptr_s = ptr_r + 4'd1;
                    if (ptr_r == 4'd15) begin
                        state_s = FIN;
                    end else begin
                        state_s = EMIT;
                    end
                end else begin
                    ptr_s = ptr_r;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        mt_valid_s = (state_s == EMIT) && mask_s[ptr_s];
    end

    // State, datapath and registered output update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            ptr_r    <= 4'd0;
            wait_r   <= 3'd0;
            mask     <= 16'd0;
            count    <= 5'd0;
            i_out    <= 4'd0;
            en_out   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mt_valid <= 1'b0;
            mt_index <= 4'd0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            wait_r   <= wait_s;
            mask     <= mask_s;
            count    <= count_s;
            i_out    <= (state_s == SCAN) ? ptr_s : 4'd0;
            en_out   <= (state_s == SCAN) ? scan_en : 1'b0;
            busy     <= (state_s == SCAN) || (state_s == EMIT);
            done     <= (state_s == FIN);
            mt_valid <= mt_valid_s;
            mt_index <= mt_valid_s ? ptr_s : 4'd0;
        end
    end

endmodule

// File: doc/minterm_scanner.md
# minterm_scanner

Sequential truth-table reader for the 4-input, single-output minterm circuits in this codebase. On `start`, it drives every input combination 0..15 into an attached minterm circuit and samples that circuit's `y` output. It builds a 16-bit minterm mask and a popcount, then streams each set minterm index out over a valid/ready port. It sits beside the combinational function block and replaces the hand-read truth table with a machine-checkable result.

## Interface
Parameters:
- `SETTLE`, default 1: extra cycles each input combination is held before `y` is sampled; range 0..7.

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle request to begin a scan; ignored unless `busy`=0
- `scan_en`  in  1  enable value forwarded to the function block during a scan
- `i_out`  out  4  input combination driven to the function block
- `en_out`  out  1  enable driven to the function block
- `y_in`  in  1  function block output
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse when scan and stream are complete
- `mask`  out  16  bit k = sampled `y` for input k
- `count`  out  5  number of set bits in `mask`, 0..16
- `mt_valid`  out  1  minterm index available
- `mt_index`  out  4  minterm index, ascending order
- `mt_ready`  in  1  consumer accepts the index

## Operation
- States: IDLE, SCAN, EMIT, FIN.
- IDLE:
  - `busy`=0.
  - `start`=1 clears `mask` and `count`, sets the index pointer to 0, and moves to SCAN.
- SCAN:
  - `i_out`=pointer and `en_out`=`scan_en`, held for SETTLE+1 cycles per index.
  - On the last cycle of each window, `y_in` is sampled into `mask[pointer]` and `count` increments if `y_in`=1.
  - The pointer then advances.
  - After index 15 is sampled, the pointer returns to 0 and the state moves to EMIT.
- EMIT:
  - The pointer walks 0..15 one position per cycle.
  - If `mask[pointer]`=0: `mt_valid`=0 and the pointer advances next cycle.
  - If `mask[pointer]`=1: `mt_valid`=1 and `mt_index`=pointer, held stable until `mt_valid`&&`mt_ready`. On transfer, the pointer advances.
  - When position 15 is handled (skipped or transferred), move to FIN.
- FIN: `done`=1 for one cycle, then return to IDLE.
- `mask` and `count` hold their final values in IDLE until the next accepted `start`.
- `start` while `busy`=1 has no effect.
- `count` is 5 bits wide so that the all-ones function (16) does not wrap.
- With `scan_en`=0, the function block outputs 0, giving `mask`=0 and `count`=0. EMIT still walks 16 cycles with `mt_valid` never high.
- `en_out`=0 and `i_out`=0 outside SCAN.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state=IDLE.
  - `i_out`=0, `en_out`=0, `busy`=0, `done`=0, `mask`=0, `count`=0, `mt_valid`=0, `mt_index`=0.
  - Reset mid-scan or mid-emit aborts with no `done` pulse.
- `busy` rises the cycle after `start` is sampled.
- SCAN lasts exactly 16×(SETTLE+1) cycles. `i_out` changes on the cycle after each sample edge.
- `y_in` must be valid SETTLE cycles after `i_out` changes. With SETTLE=0, it is sampled in the same cycle the index is driven.
- EMIT with `mt_ready` held high lasts exactly 16 cycles.
- Each low-`mt_ready` cycle on a valid index adds one cycle.
- `mt_index` and `mt_valid` must not change while `mt_valid`=1 and `mt_ready`=0.
- `done` rises the cycle after the last EMIT position and coincides with `busy` falling.
- Total latency from `start` to `done`, with `mt_ready`=1: 16×(SETTLE+1)+16+1 cycles (49 for SETTLE=1).

## Test plan
- Function block for reg no. 21BCE3546 (minterms 1,2,3,4,5,6,11,12,14), `scan_en`=1, SETTLE=1, `mt_ready`=1 → `mask`=16'h587E, `count`=9, stream 1,2,3,4,5,6,11,12,14, `done` 49 cycles after `start`.
- Same block, `scan_en`=0 → `mask`=0, `count`=0, no `mt_valid`, `done` still at 49 cycles.
- Constant-1 function → `mask`=16'hFFFF, `count`=16 (no wrap), 16 transfers in indices 0..15.
- 21BCE3546 function with `mt_ready` toggling 1-of-3 cycles → identical index sequence, `mt_index` stable during each stall, `done` delayed by exactly the stall count.
- `start` pulsed again mid-scan → ignored; results identical to a single start.
- `rst_n` low during EMIT → all outputs at reset values next cycle, no `done`; a following `start` gives correct results.
